// File: rtl/tp_tx_pkg.sv
// Shared types and defaults for the two-phase bundled-data link (tp_bd_tx and its receive-side peers).
package tp_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } tx_state_e;

  localparam int unsigned TPTX_SETUP_CYC   = 1;
  localparam int unsigned TPTX_SYNC_STAGES = 2;
  localparam int unsigned TPTX_TIMEOUT_CYC = 1024;
  localparam int unsigned SETUP_CNT_W      = 8;

endpackage

// File: rtl/tp_sync_edge.sv
// N-flop synchroniser for an asynchronous toggle signal, plus a delay flop for edge detection.
module tp_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_lvl,
  output logic o_edge_c
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign o_lvl    = r_sync[STAGES-1];
  assign o_edge_c = r_sync[STAGES-1] ^ r_dly;

endmodule

// File: rtl/tp_bd_tx.sv
// Two-phase bundled-data transmitter: holds each accepted word on tx_data, toggles tx_req, waits for a tx_ack edge.
// Optional ack timeout is enabled by defining TPTX_TIMEOUT_EN.
module tp_bd_tx
  import tp_tx_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned SETUP_CYC   = TPTX_SETUP_CYC,
  parameter int unsigned SYNC_STAGES = TPTX_SYNC_STAGES,
  parameter int unsigned TIMEOUT_CYC = TPTX_TIMEOUT_CYC,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DW-1:0]    tx_data,
  output logic             tx_req,
  input  logic             tx_ack,
  output logic             busy,
  output logic [CNT_W-1:0] sent_cnt,
  output logic             err_proto,
  output logic             err_timeout
);

  tx_state_e              r_state, w_state_nxt;
  logic [SETUP_CNT_W-1:0] r_setup, w_setup_nxt;
  logic [DW-1:0]          r_tx_data, w_tx_data_nxt;
  logic                   r_tx_req, w_tx_req_nxt;
  logic [CNT_W-1:0]       r_sent_cnt, w_sent_cnt_nxt;
  logic                   r_err_proto, w_err_proto_nxt;
  logic                   w_in_ready;
  logic                   w_ack_edge;
  logic                   w_unused_ack_lvl;

`ifdef TPTX_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic            r_err_timeout, w_err_timeout_nxt;
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
`endif

  tp_sync_edge #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk      (clk),
    .rst      (rst),
    .i_d      (tx_ack),
    .o_lvl    (w_unused_ack_lvl),
    .o_edge_c (w_ack_edge)
  );

  // Next-state and datapath updates; only ack edges matter, never the req/ack level relation.
  always_comb begin
    w_state_nxt     = r_state;
    w_setup_nxt     = r_setup;
    w_tx_data_nxt   = r_tx_data;
    w_tx_req_nxt    = r_tx_req;
    w_sent_cnt_nxt  = r_sent_cnt;
    w_err_proto_nxt = r_err_proto;
    w_in_ready      = 1'b0;
`ifdef TPTX_TIMEOUT_EN
    w_to_cnt_nxt      = r_to_cnt;
    w_err_timeout_nxt = r_err_timeout;
`endif
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (w_ack_edge) w_err_proto_nxt = 1'b1;
        if (in_valid) begin
          w_tx_data_nxt = in_data;
          w_setup_nxt   = SETUP_CNT_W'(SETUP_CYC - 1);
          w_state_nxt   = SETUP;
        end
      end
      SETUP: begin
        if (w_ack_edge) w_err_proto_nxt = 1'b1;
        if (r_setup == '0) begin
          w_tx_req_nxt = ~r_tx_req;
          w_state_nxt  = WAIT_ACK;
`ifdef TPTX_TIMEOUT_EN
          w_to_cnt_nxt = '0;
`endif
        end else begin
          w_setup_nxt = r_setup - SETUP_CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        if (w_ack_edge) begin
          w_sent_cnt_nxt = r_sent_cnt + CNT_W'(1);
          w_state_nxt    = IDLE;
        end
`ifdef TPTX_TIMEOUT_EN
        else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          w_err_timeout_nxt = 1'b1;
          w_state_nxt       = IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_setup     <= '0;
      r_tx_data   <= '0;
      r_tx_req    <= 1'b0;
      r_sent_cnt  <= '0;
      r_err_proto <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_setup     <= w_setup_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_req    <= w_tx_req_nxt;
      r_sent_cnt  <= w_sent_cnt_nxt;
      r_err_proto <= w_err_proto_nxt;
    end
  end

`ifdef TPTX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_to_cnt      <= w_to_cnt_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end
  assign err_timeout = r_err_timeout;
`else
  assign err_timeout = 1'b0;
`endif

  assign in_ready  = w_in_ready;
  assign busy      = (r_state != IDLE);
  assign tx_data   = r_tx_data;
  assign tx_req    = r_tx_req;
  assign sent_cnt  = r_sent_cnt;
  assign err_proto = r_err_proto;

endmodule

// File: tb/tb_tp_bd_tx.sv
// Self-checking bench for tp_bd_tx: randomized words and ack delays against a word-level link model.
module tb_tp_bd_tx;

  localparam int unsigned DW          = 8;
  localparam int unsigned SETUP_CYC   = 2;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    tx_data;
  logic             tx_req;
  logic             tx_ack = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] sent_cnt;
  logic             err_proto;
  logic             err_timeout;

  int n_checks = 0;
  int n_err    = 0;

  // Link model: words acknowledged so far, expected req phase, bench-side ack phase.
  int m_cnt = 0;
  bit m_req = 1'b0;
  bit m_ack = 1'b0;

  // Observations from the most recent run_word.
  logic [DW-1:0] obs_data;
  int            obs_setup;
  int            obs_ready;
  bit            obs_hold_ok;
  bit            obs_busy_ok;

  tp_bd_tx #(
    .DW(DW), .SETUP_CYC(SETUP_CYC), .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack), .busy(busy),
    .sent_cnt(sent_cnt), .err_proto(err_proto), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle_ack();
    m_ack  = ~m_ack;
    tx_ack = m_ack;
  endtask

  // Drives one word through the link as the remote would, recording what it saw.
  task automatic run_word(input logic [DW-1:0] d, input int ack_dly, input bit hold, input logic [DW-1:0] next_d);
    int  k;
    logic req0;
    obs_hold_ok = 1'b1;
    obs_busy_ok = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    in_valid = 1'b1;
    in_data  = d;
    tick();
    obs_data = tx_data;
    if (hold) in_data = next_d;
    else in_valid = 1'b0;
    req0 = 1'b0;
    req0 = m_req;
    k = 0;
    while (tx_req === req0 && k < 20) begin
      tick(); k++;
      if (tx_data !== d) obs_hold_ok = 1'b0;
    end
    obs_setup = k;
    m_req = ~m_req;
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      if (tx_data !== d) obs_hold_ok = 1'b0;
      if (busy !== 1'b1) obs_busy_ok = 1'b0;
    end
    toggle_ack();
    k = 0;
    while (!in_ready && k < 20) begin
      tick(); k++;
      if (!in_ready && tx_data !== d) obs_hold_ok = 1'b0;
    end
    obs_ready = (in_ready === 1'b1) ? k : -1;
    m_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_ack = 1'b0; m_ack = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    m_cnt = 0; m_req = 1'b0;
    n_checks++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
    n_checks++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (sent_cnt !== 4'd0) begin n_err++; $display("FAIL reset_sent_cnt: got %0d want 0", sent_cnt); end
    n_checks++; if (err_proto !== 1'b0) begin n_err++; $display("FAIL reset_err_proto: got %b want 0", err_proto); end
    n_checks++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL reset_err_timeout: got %b want 0", err_timeout); end
  endtask

  task automatic test_single();
    run_word(8'hA5, 5, 1'b0, 8'h00);
    n_checks++; if (obs_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", obs_data); end
    n_checks++; if (obs_setup != SETUP_CYC) begin n_err++; $display("FAIL single_setup: got %0d want %0d", obs_setup, SETUP_CYC); end
    n_checks++; if (tx_req !== m_req) begin n_err++; $display("FAIL single_req: got %b want %b", tx_req, m_req); end
    n_checks++; if (obs_ready != SYNC_STAGES + 1) begin n_err++; $display("FAIL single_ready_lat: got %0d want %0d", obs_ready, SYNC_STAGES + 1); end
    n_checks++; if (sent_cnt !== CNT_W'(m_cnt)) begin n_err++; $display("FAIL single_cnt: got %0d want %0d", sent_cnt, CNT_W'(m_cnt)); end
    n_checks++; if (!(obs_hold_ok && obs_busy_ok)) begin n_err++; $display("FAIL single_hold: got hold=%b busy=%b want 1 1", obs_hold_ok, obs_busy_ok); end
  endtask

  task automatic test_back_to_back();
    for (int w = 1; w <= 4; w++) begin
      run_word(DW'(w), int'($urandom_range(0, 4)), (w < 4), DW'(w + 1));
      n_checks++; if (obs_data !== DW'(w)) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", w, obs_data, DW'(w)); end
      n_checks++; if (tx_req !== m_req) begin n_err++; $display("FAIL b2b_req%0d: got %b want %b", w, tx_req, m_req); end
      n_checks++; if (!obs_hold_ok) begin n_err++; $display("FAIL b2b_hold%0d: got 0 want 1", w); end
    end
    n_checks++; if (sent_cnt !== CNT_W'(m_cnt)) begin n_err++; $display("FAIL b2b_cnt: got %0d want %0d", sent_cnt, CNT_W'(m_cnt)); end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    for (int w = 0; w < 6; w++) begin
      d = DW'($urandom);
      run_word(d, int'($urandom_range(0, 6)), 1'b0, 8'h00);
      n_checks++; if (obs_data !== d) begin n_err++; $display("FAIL rand_data%0d: got %h want %h", w, obs_data, d); end
      n_checks++; if (obs_setup != SETUP_CYC || obs_ready != SYNC_STAGES + 1) begin
        n_err++; $display("FAIL rand_timing%0d: got setup=%0d ready=%0d want %0d %0d", w, obs_setup, obs_ready, SETUP_CYC, SYNC_STAGES + 1);
      end
      n_checks++; if (sent_cnt !== CNT_W'(m_cnt)) begin n_err++; $display("FAIL rand_cnt%0d: got %0d want %0d", w, sent_cnt, CNT_W'(m_cnt)); end
    end
  endtask

  task automatic test_proto();
    toggle_ack();
    repeat (5) tick();
    n_checks++; if (err_proto !== 1'b1) begin n_err++; $display("FAIL proto_err: got %b want 1", err_proto); end
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL proto_idle: got busy=%b rdy=%b want 0 1", busy, in_ready); end
    n_checks++; if (sent_cnt !== CNT_W'(m_cnt)) begin n_err++; $display("FAIL proto_cnt: got %0d want %0d", sent_cnt, CNT_W'(m_cnt)); end
    run_word(8'h3C, 10, 1'b0, 8'h00);
    n_checks++; if (!obs_busy_ok) begin n_err++; $display("FAIL proto_wait: got early completion want busy"); end
    n_checks++; if (obs_ready != SYNC_STAGES + 1) begin n_err++; $display("FAIL proto_ready_lat: got %0d want %0d", obs_ready, SYNC_STAGES + 1); end
    n_checks++; if (sent_cnt !== CNT_W'(m_cnt)) begin n_err++; $display("FAIL proto_cnt2: got %0d want %0d", sent_cnt, CNT_W'(m_cnt)); end
  endtask

  task automatic test_wrap();
    while ((m_cnt % (1 << CNT_W)) != (1 << CNT_W) - 1) run_word(DW'($urandom), 0, 1'b0, 8'h00);
    n_checks++; if (sent_cnt !== {CNT_W{1'b1}}) begin n_err++; $display("FAIL wrap_max: got %0d want %0d", sent_cnt, (1 << CNT_W) - 1); end
    run_word(DW'($urandom), 1, 1'b0, 8'h00);
    n_checks++; if (sent_cnt !== '0) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", sent_cnt); end
  endtask

  task automatic test_timeout();
    int k;
    int cnt0;
    cnt0 = m_cnt;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (tx_req === m_req && k < 20) begin tick(); k++; end
    m_req = ~m_req;
`ifdef TPTX_TIMEOUT_EN
    k = 0;
    while (!in_ready && k < 100) begin tick(); k++; end
    n_checks++; if (k != TIMEOUT_CYC) begin n_err++; $display("FAIL timeout_lat: got %0d want %0d", k, TIMEOUT_CYC); end
    n_checks++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_err: got %b want 1", err_timeout); end
    n_checks++; if (sent_cnt !== CNT_W'(cnt0)) begin n_err++; $display("FAIL timeout_cnt: got %0d want %0d", sent_cnt, CNT_W'(cnt0)); end
    n_checks++; if (tx_req !== m_req) begin n_err++; $display("FAIL timeout_req: got %b want %b", tx_req, m_req); end
`else
    repeat (1000) tick();
    n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL noto_busy: got %b want 1", busy); end
    n_checks++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL noto_err: got %b want 0", err_timeout); end
    n_checks++; if (sent_cnt !== CNT_W'(cnt0)) begin n_err++; $display("FAIL noto_cnt: got %0d want %0d", sent_cnt, CNT_W'(cnt0)); end
    toggle_ack();
    k = 0;
    while (!in_ready && k < 20) begin tick(); k++; end
    m_cnt++;
    n_checks++; if (sent_cnt !== CNT_W'(m_cnt)) begin n_err++; $display("FAIL noto_late_cnt: got %0d want %0d", sent_cnt, CNT_W'(m_cnt)); end
`endif
  endtask

  task automatic test_rst_mid();
    int k;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (tx_req === m_req && k < 20) begin tick(); k++; end
    tick(); tick();
    n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: got %b want 1", busy); end
    rst = 1'b1; tx_ack = 1'b0; m_ack = 1'b0;
    tick();
    rst = 1'b0;
    m_cnt = 0; m_req = 1'b0;
    n_checks++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL rstmid_req: got %b want 0", tx_req); end
    n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
    n_checks++; if (sent_cnt !== '0 || err_proto !== 1'b0) begin n_err++; $display("FAIL rstmid_cnt: got cnt=%0d perr=%b want 0 0", sent_cnt, err_proto); end
    run_word(8'hC3, 2, 1'b0, 8'h00);
    n_checks++; if (sent_cnt !== CNT_W'(m_cnt) || tx_req !== m_req) begin
      n_err++; $display("FAIL rstmid_after: got cnt=%0d req=%b want %0d %b", sent_cnt, tx_req, CNT_W'(m_cnt), m_req);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_proto();
    test_wrap();
    test_timeout();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
